// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multicycle control unit and the
// instruction/data memory ports.
//   imem_req   : instruction fetch request        (master -> slave)
//   imem_ready : instruction memory data valid    (slave  -> master)
//   dm_re      : data memory read request         (master -> slave)
//   dm_we      : data memory write request        (master -> slave)
//   dmem_ready : data memory access complete      (slave  -> master)
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ready;
  logic dm_re;
  logic dm_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dm_re,
    output dm_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dm_re,
    input  dm_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects, with ready/valid
// memory handshakes, a wait-state timeout and sticky traps.
// Optional feature: define PERF_CNT_EN to build the retired-instruction counter.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   inst             : instruction register contents
//   beq              : ALU equality flag, valid in EXEC
//   mem              : memory handshake interface (master side)
//   ir_we, pc_we     : IR load / PC update strobes
//   pc_sel, RF_we    : PC source, register file write enable
//   a_sel, b_sel     : ALU operand selects
//   wb_sel, imm_sel  : writeback source, immediate format
//   alu_sel          : ALU op
//   state            : current state (debug)
//   illegal, timeout : sticky trap causes
//   instret          : retired-instruction count (0 unless PERF_CNT_EN)
module multicycle_control_unit #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     inst,
  input  logic                            beq,
  multicycle_control_unit_if.master       mem,
  output logic                            ir_we,
  output logic                            pc_we,
  output logic                            pc_sel,
  output logic                            RF_we,
  output logic                            a_sel,
  output logic                            b_sel,
  output logic [1:0]                      wb_sel,
  output logic [2:0]                      imm_sel,
  output logic [3:0]                      alu_sel,
  output logic [2:0]                      state,
  output logic                            illegal,
  output logic                            timeout,
  output logic [31:0]                     instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpcLw     = 7'b0000011;
  localparam logic [6:0] OpcSw     = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WAIT_MAX - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;
  logic             timeout_q;

  logic is_lw, is_sw, is_opi, is_op, is_jal, is_jalr, is_br, is_legal;

  assign is_lw    = (inst[6:0] == OpcLw);
  assign is_sw    = (inst[6:0] == OpcSw);
  assign is_opi   = (inst[6:0] == OpcOpImm);
  assign is_op    = (inst[6:0] == OpcOp);
  assign is_jal   = (inst[6:0] == OpcJal);
  assign is_jalr  = (inst[6:0] == OpcJalr);
  assign is_br    = (inst[6:0] == OpcBranch);
  assign is_legal = is_lw | is_sw | is_opi | is_op | is_jal | is_jalr | is_br;

  // Only the opcode, funct3 and inst[30] steer control.
  logic unused_inst;
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

  // The counter clears on every state change; a ready in the last allowed
  // wait cycle still wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (mem.imem_ready) begin
            state_q <= StDecode;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= StTrap;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDecode: begin
          if (is_legal) begin
            state_q <= StExec;
          end else begin
            state_q   <= StTrap;
            illegal_q <= 1'b1;
          end
        end
        StExec: begin
          if (is_br)              state_q <= StFetch;
          else if (is_lw | is_sw) state_q <= StMem;
          else                    state_q <= StWb;
        end
        StMem: begin
          if (mem.dmem_ready) begin
            state_q <= is_lw ? StWb : StFetch;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= StTrap;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StTrap;
        default: state_q <= StTrap;
      endcase
    end
  end

  always_comb begin
    mem.imem_req = 1'b0;
    mem.dm_re    = 1'b0;
    mem.dm_we    = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    RF_we        = 1'b0;
    a_sel        = 1'b0;
    b_sel        = 1'b0;
    wb_sel       = 2'b00;
    imm_sel      = 3'b000;
    alu_sel      = 4'b0000;
    if (!rst) begin
      // Operand selects are set up in EXEC and held through MEM and WB.
      if (state_q inside {StExec, StMem, StWb}) begin
        a_sel   = is_jal | is_br;
        b_sel   = ~is_op;
        imm_sel = is_op  ? 3'b000 :
                  is_sw  ? 3'b010 :
                  is_br  ? 3'b011 :
                  is_jal ? 3'b100 : 3'b001;
        alu_sel = is_op  ? {inst[30], inst[14:12]} :
                  is_opi ? {1'b0, inst[14:12]} : 4'b0000;
      end
      case (state_q)
        StFetch: begin
          mem.imem_req = 1'b1;
          ir_we        = mem.imem_ready;
        end
        StExec: begin
          if (is_br) begin
            pc_we  = 1'b1;
            pc_sel = inst[12] ? ~beq : beq;
          end
        end
        StMem: begin
          mem.dm_re = is_lw;
          mem.dm_we = is_sw;
          pc_we     = is_sw & mem.dmem_ready;
        end
        StWb: begin
          RF_we  = 1'b1;
          pc_we  = 1'b1;
          pc_sel = is_jal | is_jalr;
          wb_sel = is_lw ? 2'b00 : (is_op | is_opi) ? 2'b01 : 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign illegal = illegal_q & ~rst;
  assign timeout = timeout_q & ~rst;

`ifdef PERF_CNT_EN
  logic [31:0] instret_q;
  always_ff @(posedge clk) begin
    if (rst)        instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + 32'd1;
  end
  assign instret = rst ? 32'd0 : instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  localparam int unsigned WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        beq = 1'b0;
  logic        ir_we, pc_we, pc_sel, RF_we, a_sel, b_sel, illegal, timeout;
  logic [1:0]  wb_sel;
  logic [2:0]  imm_sel, state;
  logic [3:0]  alu_sel;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int retired = 0;

  multicycle_control_unit_if mif ();

  multicycle_control_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .beq     (beq),
    .mem     (mif.master),
    .ir_we   (ir_we),
    .pc_we   (pc_we),
    .pc_sel  (pc_sel),
    .RF_we   (RF_we),
    .a_sel   (a_sel),
    .b_sel   (b_sel),
    .wb_sel  (wb_sel),
    .imm_sel (imm_sel),
    .alu_sel (alu_sel),
    .state   (state),
    .illegal (illegal),
    .timeout (timeout),
    .instret (instret)
  );

  always #5 clk = ~clk;

  logic [31:0] obs;
  assign obs = {9'd0, state, mif.imem_req, ir_we, pc_we, pc_sel, RF_we, mif.dm_re, mif.dm_we,
                a_sel, b_sel, wb_sel, imm_sel, alu_sel, illegal, timeout};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [2:0] st, input logic req, input logic irw,
                                     input logic pcw, input logic pcs, input logic rfw,
                                     input logic re, input logic we, input logic as,
                                     input logic bs, input logic [1:0] wb,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic il, input logic to);
    return {9'd0, st, req, irw, pcw, pcs, rfw, re, we, as, bs, wb, imm, alu, il, to};
  endfunction

  // Entered at a falling edge with inputs set; checks outputs, then moves to
  // the next falling edge.
  task automatic cyc(input string tag, input logic [31:0] exp);
    #1;
    check_eq(tag, obs, exp);
    @(negedge clk);
  endtask

  task automatic chk_instret(input string tag);
    logic [31:0] exp;
`ifdef PERF_CNT_EN
    exp = retired;
`else
    exp = 32'd0;
`endif
    #1;
    check_eq(tag, instret, exp);
  endtask

  task automatic noise();
    mif.imem_ready = 1'($urandom);
    mif.dmem_ready = 1'($urandom);
    beq            = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      noise();
      cyc("reset", 32'd0);
    end
    rst = 1'b0;
    retired = 0;
    chk_instret("instret_after_rst");
  endtask

  task automatic trap_hold(input logic il, input logic to, input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      cyc("trap", pk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 4'h0, il, to));
    end
    do_reset(1);
  endtask

  // Reference: expected cycle trace of one instruction, built from opcode
  // class and the planned ready delays (fw/dw = wait cycles before ready).
  task automatic run_one(input logic [31:0] ins, input logic bq, input int fw, input int dw,
                         input bit rst_mem);
    logic [6:0] op;
    logic lw, sw, opr, opi, jal, jalr, br, legal, as, bs, rdy;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [1:0] wb;
    op    = ins[6:0];
    lw    = (op == 7'h03);
    sw    = (op == 7'h23);
    opi   = (op == 7'h13);
    opr   = (op == 7'h33);
    jal   = (op == 7'h6f);
    jalr  = (op == 7'h67);
    br    = (op == 7'h63);
    legal = lw | sw | opi | opr | jal | jalr | br;
    as    = jal | br;
    bs    = !opr;
    imm   = opr ? 3'd0 : sw ? 3'd2 : br ? 3'd3 : jal ? 3'd4 : 3'd1;
    alu   = opr ? {ins[30], ins[14:12]} : opi ? {1'b0, ins[14:12]} : 4'd0;
    wb    = lw ? 2'b00 : (opr | opi) ? 2'b01 : 2'b10;
    inst  = ins;

    for (int i = 0; i < int'(WAIT_MAX); i++) begin
      noise();
      rdy = (i == fw);
      mif.imem_ready = rdy;
      cyc("fetch", pk(3'd0, 1, rdy, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 4'd0, 0, 0));
      if (rdy) break;
    end
    if (fw >= int'(WAIT_MAX)) begin
      trap_hold(0, 1, int'($urandom_range(3, 20)));
      return;
    end

    noise();
    cyc("decode", pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 4'd0, 0, 0));
    if (!legal) begin
      trap_hold(1, 0, 20);
      return;
    end

    noise();
    beq = bq;
    cyc("exec", pk(3'd2, 0, 0, br, br & (ins[12] ? !bq : bq), 0, 0, 0, as, bs, 2'b00, imm,
                   alu, 0, 0));
    if (br) begin
      retired++;
      chk_instret("instret_br");
      return;
    end

    if (lw | sw) begin
      for (int i = 0; i < int'(WAIT_MAX); i++) begin
        noise();
        if (rst_mem && i == 1) begin
          do_reset(1);
          return;
        end
        rdy = (i == dw);
        mif.dmem_ready = rdy;
        cyc("mem", pk(3'd3, 0, 0, sw & rdy, 0, 0, lw, sw, as, bs, 2'b00, imm, alu, 0, 0));
        if (rdy) break;
      end
      if (dw >= int'(WAIT_MAX)) begin
        trap_hold(0, 1, int'($urandom_range(3, 20)));
        return;
      end
      if (sw) begin
        retired++;
        chk_instret("instret_sw");
        return;
      end
    end

    noise();
    cyc("wb", pk(3'd4, 0, 0, 1, jal | jalr, 1, 0, 0, as, bs, wb, imm, alu, 0, 0));
    retired++;
    chk_instret("instret_wb");
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 11) == 0) return int'($urandom_range(13, 16));
    return int'($urandom_range(0, 3));
  endfunction

  logic [6:0] legal_ops [7] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h6f, 7'h67, 7'h63};

  initial begin
    logic [31:0] ri;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    @(negedge clk);
    do_reset(2);

    run_one(32'h00500093, 0, 0, 0, 0);     // ADDI x1,x0,5
    run_one(32'h0000A103, 0, 0, 3, 0);     // LW, dmem ready after 3 waits
    run_one(32'h00209463, 0, 0, 0, 0);     // BNE, not equal: taken
    run_one(32'h00209463, 1, 0, 0, 0);     // BNE, equal: not taken
    run_one(32'h0000007F, 0, 0, 0, 0);     // illegal opcode
    run_one(32'h00500093, 0, 15, 0, 0);    // imem never ready: timeout
    run_one(32'h00500093, 0, 14, 0, 0);    // ready on last allowed cycle
    run_one(32'h0020A023, 0, 0, 14, 0);    // SW ready on last allowed cycle
    run_one(32'h0000A103, 0, 0, 15, 0);    // LW dmem timeout
    for (int i = 0; i < 10; i++) run_one(32'h00100093, 0, 0, 0, 0);
    run_one(32'h0020A023, 0, 0, 10, 1);    // SW with reset mid-MEM
    run_one(32'h0040006F, 0, 1, 0, 0);     // JAL
    run_one(32'h000080E7, 0, 2, 0, 0);     // JALR
    run_one(32'h40208033, 0, 0, 0, 0);     // SUB

    for (int n = 0; n < 250; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 9) != 0) ri[6:0] = legal_ops[$urandom_range(0, 6)];
      run_one(ri, 1'($urandom), pick_wait(), pick_wait(), ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the single-cycle RV32I control unit, for the multicycle core. FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the existing datapath selects: pc_sel, RF_we, dm_we, a_sel, b_sel, wb_sel, imm_sel and alu_sel, with the same encodings. Adds ready/valid memory handshakes, wait-state timeout, and a sticky trap for illegal opcodes. Sits between the IR/datapath and the instruction/data memory ports.

Parameters:
WAIT_MAX, 15, max cycles spent waiting on imem_ready/dmem_ready before timeout trap (1..255)
CNT_W, 4, width of wait counter; must satisfy 2^CNT_W > WAIT_MAX

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
inst  in  32  instruction register contents (stable from DECODE until next ir_we)
beq  in  1  ALU equality flag (rs1==rs2), valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  load IR from instruction memory
pc_we  out  1  update PC this cycle
pc_sel  out  1  0: PC+4, 1: ALU target
RF_we  out  1  register file write enable
dm_re  out  1  data memory read request
dm_we  out  1  data memory write request
a_sel  out  1  0: rs1, 1: PC
b_sel  out  1  0: rs2, 1: imm
wb_sel  out  2  00 mem, 01 ALU, 10 PC+4
imm_sel  out  3  000 none, 001 I, 010 S, 011 B, 100 J
alu_sel  out  4  ALU op
state  out  3  current state, for debug
illegal  out  1  sticky: unsupported opcode trapped
timeout  out  1  sticky: memory handshake timeout
instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Outputs are combinational from the registered state and inst.
- Reset: state=FETCH, wait counter=0, illegal=0, timeout=0, instret=0. While rst is high, every output is 0 except state=0. imem_req is qualified with ~rst.
- FETCH: imem_req=1. On imem_ready: ir_we=1 in the same cycle, then go to DECODE. Otherwise increment the wait counter. If the counter reaches WAIT_MAX with no ready, go to TRAP and set timeout=1.
- DECODE: no strobes. inst[6:0] is LW 0000011, SW 0100011, OP_I 0010011, OP 0110011, JAL 1101111, JALR 1100111, or BRANCH 1100011: go to EXEC. Any other opcode: go to TRAP and set illegal=1.
- EXEC: drive a_sel/b_sel/imm_sel/alu_sel per opcode.
  - OP: alu_sel={inst[30],inst[14:12]}.
  - OP_I: alu_sel={0,inst[14:12]}.
  - All others: alu_sel=0000.
  - a_sel=1 only for JAL/BRANCH. b_sel=0 only for OP.
  - BRANCH: pc_we=1, pc_sel = inst[12] ? ~beq : beq, RF_we=0, then go to FETCH (retire).
  - LW/SW: go to MEM. OP/OP_I/JAL/JALR: go to WB.
- MEM: hold the EXEC selects.
  - LW: dm_re=1. SW: dm_we=1.
  - On dmem_ready: LW goes to WB. SW goes to FETCH with pc_we=1, pc_sel=0 (retire).
  - Same WAIT_MAX timeout rule as FETCH; strobes drop in the TRAP cycle.
- WB: RF_we=1, pc_we=1 (retire), then go to FETCH.
  - wb_sel: LW 00, OP/OP_I 01, JAL/JALR 10.
  - pc_sel: 1 for JAL/JALR, else 0.
- TRAP: all strobes 0, illegal/timeout held, stays in TRAP until rst.
- Wait counter clears on every state change. A ready that arrives in the same cycle the counter hits WAIT_MAX wins: no trap.
- Reset asserted in any state, including mid-MEM with dm_we high: state is FETCH in the next cycle and strobes are 0 during reset.
- Latency: BRANCH 3 cycles, SW 4, ALU/JAL/JALR 4, LW 5 (each with zero wait states).

Optional Feature:
- PERF_CNT_EN defined: instret increments by 1 (wrapping modulo 2^32) on every retire cycle, i.e. every cycle with pc_we=1. Cleared by rst.
- Not defined: instret is tied to 0 and the counter logic is absent.

Test Plan:
- ADDI x1,x0,5 (0x00500093), imem_ready=1 and dmem_ready=1 throughout → states 0,1,2,4,0. In WB: RF_we=1, wb_sel=01, alu_sel=0000, imm_sel=001.
- LW (0x0000A103) with dmem_ready delayed 3 cycles → dm_re high 4 cycles in MEM, then WB with wb_sel=00, RF_we=1. Total latency 8 cycles.
- BNE (inst[12]=1) with beq=0 → pc_we=1, pc_sel=1, RF_we=0 in EXEC. Repeat with beq=1 → pc_sel=0.
- Opcode 0x7F → TRAP after DECODE, illegal=1, all strobes 0 for 20 cycles. Then rst for 1 cycle → state=0, illegal=0.
- imem_ready held low, WAIT_MAX=15 → TRAP entered after 15 waiting cycles with timeout=1. Second run with ready asserted on the 15th cycle → no trap.
- With PERF_CNT_EN: 10 ADDIs → instret=10. Assert rst mid-MEM of an SW → dm_we=0 during reset, instret=0 after.
